// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand/result sequencer.
package alu_seq_pkg;

    localparam int DATA_W   = 8;

    // Control bits in the instruction byte (bits 7:3 belong to the ALU decoder)
    localparam int REUSE_A  = 0;
    localparam int REUSE_B  = 1;
    localparam int FLAG_UPD = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4
    } state_t;

    // First state after accepting an instruction: skip operand loads the
    // instruction says to reuse.
    function automatic state_t first_state(input logic [DATA_W-1:0] i_instr);
        if (!i_instr[REUSE_A]) return LOAD_A;
        else if (!i_instr[REUSE_B]) return LOAD_B;
        else return EXEC;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Handshake and bus bundle between the sequencer and its datapath neighbours
// (instruction source, operand source, main_reg, ALU, result sink).
interface alu_sequencer_if;
    import alu_seq_pkg::*;

    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] opnd;
    logic              opnd_valid;
    logic              opnd_ready;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] bus_out;
    logic              bus_oe;
    logic              a_r_n;
    logic              b_r_n;
    logic [DATA_W-1:0] alu_o;
    logic              pre_carry;
    logic              pre_lt;
    logic              pre_z;
    logic              fl_carry;
    logic              fl_lt;
    logic              fl_z;
    logic [DATA_W-1:0] res_data;
    logic              res_valid;
    logic              res_ready;

    // Sequencer side
    modport master (
        input  instr, instr_valid, opnd, opnd_valid, alu_o,
               pre_carry, pre_lt, pre_z, res_ready,
        output instr_ready, opnd_ready, ir, bus_out, bus_oe, a_r_n, b_r_n,
               fl_carry, fl_lt, fl_z, res_data, res_valid
    );

    // Environment side
    modport slave (
        output instr, instr_valid, opnd, opnd_valid, alu_o,
               pre_carry, pre_lt, pre_z, res_ready,
        input  instr_ready, opnd_ready, ir, bus_out, bus_oe, a_r_n, b_r_n,
               fl_carry, fl_lt, fl_z, res_data, res_valid
    );

endinterface

// File: rtl/alu_sequencer_flag_reg.sv
// Three-bit flag register {carry, lt, z}: loads on i_load, otherwise holds.
module flag_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [2:0] i_d,
    output logic [2:0] o_q
);

    logic [2:0] r_q;

    // Flags clear on reset and change only when explicitly loaded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_q <= 3'b000;
        else if (i_load) r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/alu_sequencer.sv
// ALU sequencer: accepts an instruction, loads up to two operands onto the
// main_reg bus, captures the ALU result (and optionally flags) and hands the
// result out. Optional feature macro: ALU_SEQ_OPCOUNT_EN adds op_count[15:0],
// a wrapping count of completed operations.
//
// state  | meaning
// IDLE   | waiting for an instruction, instr_ready high
// LOAD_A | waiting for operand A, strobes a_r_n in the handshake cycle
// LOAD_B | waiting for operand B, strobes b_r_n in the handshake cycle
// EXEC   | single cycle: capture alu_o and, if requested, the pre-flags
// WB     | result offered on res_valid until res_ready
module alu_sequencer
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    alu_sequencer_if.master   sif
`ifdef ALU_SEQ_OPCOUNT_EN
    ,
    output logic [15:0]       op_count
`endif
);

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_res;
    logic [2:0]        w_flags;

    logic              w_instr_ready;
    logic              w_opnd_ready;
    logic              w_bus_oe;
    logic [DATA_W-1:0] w_bus_out;
    logic              w_a_r_n;
    logic              w_b_r_n;
    logic              w_res_valid;
    logic              w_ir_load;
    logic              w_exec;
    logic              w_done;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state and handshake/strobe decode; strobes are only ever asserted
    // in a LOAD state's handshake cycle, so a_r_n and b_r_n cannot overlap
    always_comb begin
        w_next        = r_state;
        w_instr_ready = 1'b0;
        w_opnd_ready  = 1'b0;
        w_bus_oe      = 1'b0;
        w_bus_out     = '0;
        w_a_r_n       = 1'b1;
        w_b_r_n       = 1'b1;
        w_res_valid   = 1'b0;
        w_ir_load     = 1'b0;
        w_exec        = 1'b0;
        w_done        = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_instr_ready = 1'b1;
                if (sif.instr_valid) begin
                    w_ir_load = 1'b1;
                    w_next    = first_state(sif.instr);
                end
            end
            LOAD_A: begin
                w_opnd_ready = 1'b1;
                if (sif.opnd_valid) begin
                    w_bus_oe  = 1'b1;
                    w_bus_out = sif.opnd;
                    w_a_r_n   = 1'b0;
                    w_next    = r_ir[REUSE_B] ? EXEC : LOAD_B;
                end
            end
            LOAD_B: begin
                w_opnd_ready = 1'b1;
                if (sif.opnd_valid) begin
                    w_bus_oe  = 1'b1;
                    w_bus_out = sif.opnd;
                    w_b_r_n   = 1'b0;
                    w_next    = EXEC;
                end
            end
            EXEC: begin
                w_exec = 1'b1;
                w_next = WB;
            end
            WB: begin
                w_res_valid = 1'b1;
                if (sif.res_ready) begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Instruction register: loaded only on accept, so it holds until IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_ir <= '0;
        else if (w_ir_load) r_ir <= sif.instr;
    end

    // Result register: captured in EXEC, stable through WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_res <= '0;
        else if (w_exec) r_res <= sif.alu_o;
    end

    flag_reg u_flag_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_exec && r_ir[FLAG_UPD]),
        .i_d    ({sif.pre_carry, sif.pre_lt, sif.pre_z}),
        .o_q    (w_flags)
    );

`ifdef ALU_SEQ_OPCOUNT_EN
    logic [15:0] r_op_count;

    // Completed-operation counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_op_count <= '0;
        else if (w_done) r_op_count <= r_op_count + 16'd1;
    end

    assign op_count = r_op_count;
`endif

    assign sif.instr_ready = w_instr_ready;
    assign sif.opnd_ready  = w_opnd_ready;
    assign sif.ir          = r_ir;
    assign sif.bus_out     = w_bus_out;
    assign sif.bus_oe      = w_bus_oe;
    assign sif.a_r_n       = w_a_r_n;
    assign sif.b_r_n       = w_b_r_n;
    assign sif.fl_carry    = w_flags[2];
    assign sif.fl_lt       = w_flags[1];
    assign sif.fl_z        = w_flags[0];
    assign sif.res_data    = r_res;
    assign sif.res_valid   = w_res_valid;

endmodule
